// File: rtl/vga_timing_if.sv
// Output bundle of the VGA timing generator: pixel position, region decodes,
// start pulses and the delayed active-low VGA sync pair.
interface vga_timing_if;
  logic [9:0] col_count_o;
  logic [9:0] row_count_o;
  logic       Hsync_o;
  logic       Vsync_o;
  logic       active_o;
  logic       line_start_o;
  logic       frame_start_o;
  logic       Hsync_vga_o;
  logic       Vsync_vga_o;

  modport master (
    output col_count_o, row_count_o, Hsync_o, Vsync_o, active_o,
    output line_start_o, frame_start_o, Hsync_vga_o, Vsync_vga_o
  );

  modport slave (
    input col_count_o, row_count_o, Hsync_o, Vsync_o, active_o,
    input line_start_o, frame_start_o, Hsync_vga_o, Vsync_vga_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 VGA pixel-timing generator: column/row counters, active-region decodes,
// line/frame start pulses and delayed active-low VGA sync pulses.
module vga_timing_gen #(
  parameter int unsigned TOTAL_COLS    = 800,
  parameter int unsigned TOTAL_ROWS    = 525,
  parameter int unsigned ACTIVE_COLS   = 640,
  parameter int unsigned ACTIVE_ROWS   = 480,
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_SYNC_WIDTH  = 96,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_SYNC_WIDTH  = 2,
  parameter int unsigned VIDEO_DELAY   = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  vga_timing_if.master vga
);

  localparam logic [9:0] ColLast   = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] RowLast   = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ColActive = 10'(ACTIVE_COLS);
  localparam logic [9:0] RowActive = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HsStart   = 10'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [9:0] HsEnd     = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [9:0] VsStart   = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [9:0] VsEnd     = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  logic [9:0] col_q, row_q;
  logic [9:0] col_d, row_d;
  logic       hsync_q, vsync_q, active_q;
  logic       line_start_q, frame_start_q;
  logic       hraw_q, vraw_q;
  logic       col_last, row_last;

  // Next pixel position; decodes below are taken from this so that every
  // registered output describes the same pixel as the counters.
  always_comb begin
    col_last = (col_q == ColLast);
    row_last = (row_q == RowLast);
    col_d    = col_q + 10'd1;
    row_d    = row_q;
    if (col_last) begin
      col_d = '0;
      row_d = row_last ? '0 : row_q + 10'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q         <= ColLast;
      row_q         <= RowLast;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hraw_q        <= 1'b1;
      vraw_q        <= 1'b1;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (en_i) begin
        col_q         <= col_d;
        row_q         <= row_d;
        hsync_q       <= (col_d < ColActive);
        vsync_q       <= (row_d < RowActive);
        active_q      <= (col_d < ColActive) && (row_d < RowActive);
        line_start_q  <= (col_d == '0);
        frame_start_q <= (col_d == '0) && (row_d == '0);
        hraw_q        <= !((col_d >= HsStart) && (col_d <= HsEnd));
        vraw_q        <= !((row_d >= VsStart) && (row_d <= VsEnd));
      end
    end
  end

  assign vga.col_count_o   = col_q;
  assign vga.row_count_o   = row_q;
  assign vga.Hsync_o       = hsync_q;
  assign vga.Vsync_o       = vsync_q;
  assign vga.active_o      = active_q;
  assign vga.line_start_o  = line_start_q;
  assign vga.frame_start_o = frame_start_q;

  // Sync delay line runs on every clk so it drains even while en_i is low.
  if (VIDEO_DELAY == 0) begin : g_no_delay
    assign vga.Hsync_vga_o = hraw_q;
    assign vga.Vsync_vga_o = vraw_q;
  end else begin : g_delay
    logic [VIDEO_DELAY-1:0] hdly_q, vdly_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hdly_q <= '1;
        vdly_q <= '1;
      end else begin
        hdly_q[0] <= hraw_q;
        vdly_q[0] <= vraw_q;
        for (int k = 1; k < int'(VIDEO_DELAY); k++) begin
          hdly_q[k] <= hdly_q[k-1];
          vdly_q[k] <= vdly_q[k-1];
        end
      end
    end

    assign vga.Hsync_vga_o = hdly_q[VIDEO_DELAY-1];
    assign vga.Vsync_vga_o = vdly_q[VIDEO_DELAY-1];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-geometry instance and a default 640x480
// instance share stimulus and are checked every clk against a position model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  vga_timing_if vga0 ();
  vga_timing_if vga1 ();

  vga_timing_gen #(
    .TOTAL_COLS(40), .TOTAL_ROWS(20), .ACTIVE_COLS(32), .ACTIVE_ROWS(15),
    .H_FRONT_PORCH(2), .H_SYNC_WIDTH(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2),
    .VIDEO_DELAY(3)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vga(vga0)
  );

  vga_timing_gen dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .vga(vga1)
  );

  // Per-instance geometry: {cols, rows, act_cols, act_rows, hfp, hsw, vfp, vsw, delay}
  int g_c[2]   = '{40, 800};
  int g_r[2]   = '{20, 525};
  int g_ac[2]  = '{32, 640};
  int g_ar[2]  = '{15, 480};
  int g_hfp[2] = '{2, 16};
  int g_hsw[2] = '{4, 96};
  int g_vfp[2] = '{1, 10};
  int g_vsw[2] = '{2, 2};
  int g_d[2]   = '{3, 2};

  logic [9:0] d_col[2], d_row[2];
  logic       d_hs[2], d_vs[2], d_act[2], d_ls[2], d_fs[2], d_hv[2], d_vv[2];

  assign d_col[0] = vga0.col_count_o;   assign d_col[1] = vga1.col_count_o;
  assign d_row[0] = vga0.row_count_o;   assign d_row[1] = vga1.row_count_o;
  assign d_hs[0]  = vga0.Hsync_o;       assign d_hs[1]  = vga1.Hsync_o;
  assign d_vs[0]  = vga0.Vsync_o;       assign d_vs[1]  = vga1.Vsync_o;
  assign d_act[0] = vga0.active_o;      assign d_act[1] = vga1.active_o;
  assign d_ls[0]  = vga0.line_start_o;  assign d_ls[1]  = vga1.line_start_o;
  assign d_fs[0]  = vga0.frame_start_o; assign d_fs[1]  = vga1.frame_start_o;
  assign d_hv[0]  = vga0.Hsync_vga_o;   assign d_hv[1]  = vga1.Hsync_vga_o;
  assign d_vv[0]  = vga0.Vsync_vga_o;   assign d_vv[1]  = vga1.Vsync_vga_o;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: linear pixel index within the frame plus the raw-pulse history.
  int  m_p[2];
  bit  m_hraw[2], m_vraw[2], m_ls[2], m_fs[2];
  bit  m_hq[2][8], m_vq[2][8];
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_p[i]    = g_c[i] * g_r[i] - 1;
        m_hraw[i] = 1'b1;
        m_vraw[i] = 1'b1;
        m_ls[i]   = 1'b0;
        m_fs[i]   = 1'b0;
        for (int k = 0; k < 8; k++) begin
          m_hq[i][k] = 1'b1;
          m_vq[i][k] = 1'b1;
        end
      end
    end else if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 7; k > 0; k--) begin
          m_hq[i][k] = m_hq[i][k-1];
          m_vq[i][k] = m_vq[i][k-1];
        end
        m_hq[i][0] = m_hraw[i];
        m_vq[i][0] = m_vraw[i];
        m_ls[i] = 1'b0;
        m_fs[i] = 1'b0;
        if (en) begin
          int col, row, hs0, vs0;
          m_p[i] = (m_p[i] + 1) % (g_c[i] * g_r[i]);
          col = m_p[i] % g_c[i];
          row = m_p[i] / g_c[i];
          hs0 = g_ac[i] + g_hfp[i];
          vs0 = g_ar[i] + g_vfp[i];
          m_hraw[i] = !(col >= hs0 && col < hs0 + g_hsw[i]);
          m_vraw[i] = !(row >= vs0 && row < vs0 + g_vsw[i]);
          m_ls[i]   = (col == 0);
          m_fs[i]   = (m_p[i] == 0);
        end
      end
    end
  end

  // Compare process: every clk once the model has seen a reset.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        int col, row;
        bit ehv, evv;
        col = m_p[i] % g_c[i];
        row = m_p[i] / g_c[i];
        ehv = (g_d[i] == 0) ? m_hraw[i] : m_hq[i][g_d[i]-1];
        evv = (g_d[i] == 0) ? m_vraw[i] : m_vq[i][g_d[i]-1];
        chk($sformatf("col[%0d]", i), int'(d_col[i]), col);
        chk($sformatf("row[%0d]", i), int'(d_row[i]), row);
        chk($sformatf("hsync[%0d]", i), int'(d_hs[i]), int'(col < g_ac[i]));
        chk($sformatf("vsync[%0d]", i), int'(d_vs[i]), int'(row < g_ar[i]));
        chk($sformatf("active[%0d]", i), int'(d_act[i]),
            int'(col < g_ac[i] && row < g_ar[i]));
        chk($sformatf("line_start[%0d]", i), int'(d_ls[i]), int'(m_ls[i]));
        chk($sformatf("frame_start[%0d]", i), int'(d_fs[i]), int'(m_fs[i]));
        chk($sformatf("hsync_vga[%0d]", i), int'(d_hv[i]), int'(ehv));
        chk($sformatf("vsync_vga[%0d]", i), int'(d_vv[i]), int'(evv));
      end
    end
  end

  task automatic tick(input logic e, input logic r);
    en  = e;
    rst = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int fs0, fs1, n;
    bit found;

    // Reset state, then the first strobe loads (0,0).
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("rst_col", int'(d_col[1]), 799);
    chk("rst_row", int'(d_row[1]), 524);
    chk("rst_hvga", int'(d_hv[1]), 1);
    tick(1'b1, 1'b0);
    chk("first_col", int'(d_col[1]), 0);
    chk("first_row", int'(d_row[1]), 0);
    chk("first_active", int'(d_act[1]), 1);
    chk("first_fs", int'(d_fs[1]), 1);
    chk("first_ls", int'(d_ls[1]), 1);
    tick(1'b0, 1'b0);
    chk("fs_one_clk", int'(d_fs[1]), 0);

    // Every-other-clk strobes up to col 656 on the default instance.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      tick(1'b1, 1'b0);
      if (d_col[1] == 10'd656) found = 1'b1;
      else tick(1'b0, 1'b0);
    end
    chk("reach_656", int'(found), 1);
    chk("hvga_656_t0", int'(d_hv[1]), 1);
    tick(1'b0, 1'b0);
    chk("hvga_656_t1", int'(d_hv[1]), 1);
    tick(1'b0, 1'b0);
    chk("hvga_656_t2", int'(d_hv[1]), 0);

    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      tick(1'b1, 1'b0);
      if (d_col[1] == 10'd799) found = 1'b1;
      else tick(1'b0, 1'b0);
    end
    chk("reach_799", int'(found), 1);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    chk("wrap_col", int'(d_col[1]), 0);
    chk("wrap_row", int'(d_row[1]), 1);
    chk("wrap_ls", int'(d_ls[1]), 1);
    chk("wrap_fs", int'(d_fs[1]), 0);

    // Hold en low at col 0: frozen counters, no repeated pulses.
    for (int k = 0; k < 50; k++) begin
      tick(1'b0, 1'b0);
      chk("hold_col", int'(d_col[1]), 0);
      chk("hold_ls", int'(d_ls[1]), 0);
    end

    // Random strobes with an occasional mid-frame reset (model tracks it).
    for (int k = 0; k < 4000; k++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 999) == 0));
    end

    // Mid-frame reset together with en.
    repeat (37) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    chk("midrst_col", int'(d_col[1]), 799);
    chk("midrst_row", int'(d_row[1]), 524);
    chk("midrst_ls", int'(d_ls[1]), 0);
    tick(1'b1, 1'b0);
    chk("postrst_col", int'(d_col[1]), 0);
    chk("postrst_fs", int'(d_fs[1]), 1);

    // Small instance frame = 800 strobes: two frame starts in 1600 strobes.
    tick(1'b0, 1'b1);
    fs0 = 0;
    fs1 = 0;
    n   = 0;
    repeat (1600) begin
      tick(1'b1, 1'b0);
      n++;
      fs0 += int'(d_fs[0]);
      fs1 += int'(d_fs[1]);
    end
    chk("frames_small", fs0, 2);
    chk("frames_default", fs1, 1);
    chk("strobes", n, 1600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-timing generator for the 640x480 VGA display path. It produces the column and row pixel counters and the active-region-high `Hsync_o`/`Vsync_o` pair that the game top level consumes on its `Hsync_i`/`Vsync_i` inputs. It also produces true active-low VGA sync pulses, with front porch, sync width and back porch applied, delayed to line up with the downstream video pipeline. It sits at the head of the video chain and is driven by the system clock plus a pixel-rate enable.

## Interface
Parameters:
- `TOTAL_COLS`, 800: pixels per line, including blanking.
- `TOTAL_ROWS`, 525: lines per frame, including blanking.
- `ACTIVE_COLS`, 640: visible pixels per line.
- `ACTIVE_ROWS`, 480: visible lines per frame.
- `H_FRONT_PORCH`, 16: columns from the end of the active region to the start of the H sync pulse.
- `H_SYNC_WIDTH`, 96: H sync pulse width, in columns.
- `V_FRONT_PORCH`, 10: rows from the end of the active region to the start of the V sync pulse.
- `V_SYNC_WIDTH`, 2: V sync pulse width, in rows.
- `VIDEO_DELAY`, 2: extra `clk_i` cycles of delay on the VGA sync pulses, legal range 0..7.

Ports:
- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: pixel strobe; the position advances one pixel per clock with `en_i`=1.
- `col_count_o`, out, 10: current column, 0..TOTAL_COLS-1.
- `row_count_o`, out, 10: current row, 0..TOTAL_ROWS-1.
- `Hsync_o`, out, 1: 1 while col < ACTIVE_COLS (active-region format).
- `Vsync_o`, out, 1: 1 while row < ACTIVE_ROWS (active-region format).
- `active_o`, out, 1: `Hsync_o` & `Vsync_o`.
- `line_start_o`, out, 1: one-clk pulse when col 0 is loaded, on any row.
- `frame_start_o`, out, 1: one-clk pulse when pixel (0,0) is loaded.
- `Hsync_vga_o`, out, 1: active-low H sync pulse, delayed by VIDEO_DELAY.
- `Vsync_vga_o`, out, 1: active-low V sync pulse, delayed by VIDEO_DELAY.

## Operation
- All outputs are registered. Only clocks with `en_i`=1 advance the position.
- Column counter:
  - On en_i, col increments.
  - At TOTAL_COLS-1, col wraps to 0 and row increments.
  - When row is TOTAL_ROWS-1 at that wrap, row also wraps to 0.
- Decodes are computed from the next position and registered together with the counters. `col_count_o`, `row_count_o`, `Hsync_o`, `Vsync_o`, `active_o` and the start pulses therefore always describe the same pixel.
- `line_start_o` and `frame_start_o` are high for exactly one clk, after the en_i clock that loads col 0 (or (0,0)).
  - They are cleared on the next clk even if `en_i` is low.
  - They never repeat while `en_i` is held low.
- Raw VGA H pulse is low for col in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1]; with defaults that is 656..751. The V pulse uses rows the same way (490..491 with defaults).
- Raw VGA pulses pass through a VIDEO_DELAY-deep shift register that is clocked every `clk_i`, not gated by en_i. With VIDEO_DELAY=0 the pulses come directly from the decode register.
- Parameter legality: ACTIVE+FRONT_PORCH+SYNC_WIDTH <= TOTAL, per axis. Illegal values are unsupported; no check is required.
- Reset mid-frame: on the clk after `rst_i` is sampled high, all state returns to reset values. No partial line or frame is completed.

## Timing
- Reset values:
  - `col_count_o`=TOTAL_COLS-1, `row_count_o`=TOTAL_ROWS-1.
  - `Hsync_o`=0, `Vsync_o`=0, `active_o`=0.
  - `line_start_o`=0, `frame_start_o`=0.
  - `Hsync_vga_o`=1, `Vsync_vga_o`=1; all delay stages are 1.
- Because reset parks the counters at the last pixel, the first en_i after reset loads (0,0) and pulses both `frame_start_o` and `line_start_o`.
- Latency:
  - Counters and decodes update 1 clk after the en_i clock.
  - VGA syncs lag the same pixel's counters by VIDEO_DELAY clks.
- `rst_i` has priority over `en_i` on the same clock.
- The frame period is TOTAL_COLS*TOTAL_ROWS en_i strobes; 420000 with defaults.

## Test plan
- Reset, then one en_i: col=0, row=0, `Hsync_o`=`Vsync_o`=`active_o`=1, `frame_start_o`=`line_start_o`=1 for exactly 1 clk.
- en_i every other clk, through col 799: next strobe gives col=0 and row+1, with `line_start_o` pulsed once and `frame_start_o`=0. `Hsync_o` falls at col 640 and rises at col 0.
- H pulse, with VIDEO_DELAY=2: `Hsync_vga_o` goes low 2 clks after col=656 is presented and stays low for 96 strobes (rises 2 clks after col=752). `Vsync_vga_o` is low only on rows 490..491.
- Full frame: from (799,524), one strobe gives (0,0) with `frame_start_o`=1. Exactly one `frame_start_o` per 420000 strobes; `Vsync_o` is 0 on rows 480..524.
- Hold `en_i`=0 for 50 clks at col 0: counters are frozen, start pulses are not repeated, and the VGA delay line still drains.
- Assert `rst_i` at (300,200) together with `en_i`=1: the next clk shows reset values; the first post-reset strobe gives (0,0) with `frame_start_o`=1.
